mem_port_arbiter: RTL and testbench

- Shares the single on-chip memory port between three requesters: debug module system-bus access (index 0), core data port (index 1) and core instruction fetch (index 2).
- Sequences one transaction at a time and holds it while memory stalls. Memory stalls are signalled by mem_ready low, the same condition the bench models with its inhibit stimulus.
- Routes the read data or write acknowledge back to the granted requester.
- Sits inside top between the core, the debug module and the memory wrapper.

---
 rtl/arb_pkg.sv | 15 +
 rtl/arb_priority_picker.sv | 33 +++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the memory port arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ_DEFAULT = 3;
  localparam int unsigned REQ_DBG         = 0;
  localparam int unsigned REQ_DMEM        = 1;
  localparam int unsigned REQ_IMEM        = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_e;

endpackage

// File: rtl/arb_priority_picker.sv
// Combinational winner selection for the memory port arbiter.
// Fixed priority, lowest index wins. With ARB_ROUND_ROBIN_EN defined, debug keeps
// absolute priority and the data/instruction ports alternate when both request.
module arb_priority_picker
  import arb_pkg::*;
#(
  parameter int unsigned  NUM_REQ = NUM_REQ_DEFAULT,
  localparam int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
`ifdef ARB_ROUND_ROBIN_EN
  // 1: instruction port is due next, 0: data port is due next
  input  logic               rr_ptr_i,
`endif
  output logic [IdxW-1:0]    idx_o,
  output logic               valid_o
);

  // Lowest set index wins; round-robin override applies only to the 1-vs-2 tie.
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IdxW'(i);
    end
`ifdef ARB_ROUND_ROBIN_EN
    if (!req_i[REQ_DBG] && req_i[REQ_DMEM] && req_i[REQ_IMEM] && rr_ptr_i) begin
      idx_o = IdxW'(REQ_IMEM);
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between debug SBA (0), core data (1) and core fetch (2).
// One transaction at a time: IDLE picks and latches, ISSUE holds mem_req until
// mem_ready, WAIT routes the completion back to the owner.
// Optional macro ARB_ROUND_ROBIN_EN: alternate requesters 1 and 2 on contention.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned  NUM_REQ = NUM_REQ_DEFAULT,
  parameter int unsigned  ADDR_W  = 32,
  parameter int unsigned  DATA_W  = 32,
  localparam int unsigned BeW     = DATA_W / 8,
  localparam int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ*BeW-1:0]    be_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      busy_o,
  output logic [IdxW-1:0]           owner_o,
  output logic                      mem_req_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  output logic                      mem_we_o,
  output logic [BeW-1:0]            mem_be_o,
  input  logic                      mem_ready_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_W-1:0]         mem_rdata_i
);

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [BeW-1:0]      mem_be_q, mem_be_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [IdxW-1:0]     pick_idx;
  logic                pick_valid;

  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
  logic [BeW-1:0]      be_arr    [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = addr_i[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = wdata_i[g*DATA_W +: DATA_W];
    assign be_arr[g]    = be_i[g*BeW +: BeW];
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;

  // Remember which of the data/fetch ports was granted last.
  always_comb begin
    rr_d = rr_q;
    if (gnt_o[REQ_DMEM]) rr_d = 1'b1;
    if (gnt_o[REQ_IMEM]) rr_d = 1'b0;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= 1'b0;
    else         rr_q <= rr_d;
  end
`endif

  arb_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i    (req_i),
`ifdef ARB_ROUND_ROBIN_EN
    .rr_ptr_i (rr_q),
`endif
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Next-state, transaction latch and the combinational grant pulse.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    gnt_o       = '0;
    unique case (state_q)
      ARB_IDLE: begin
        // A stray mem_rvalid here is deliberately ignored.
        if (pick_valid) begin
          state_d     = ARB_ISSUE;
          owner_d     = pick_idx;
          mem_addr_d  = addr_arr[pick_idx];
          mem_wdata_d = wdata_arr[pick_idx];
          mem_we_d    = we_i[pick_idx];
          mem_be_d    = be_arr[pick_idx];
        end
      end
      ARB_ISSUE: begin
        if (mem_ready_i) begin
          gnt_o[owner_q] = 1'b1;
          state_d        = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_rvalid_i) begin
          rvalid_d[owner_q] = 1'b1;
          rdata_d           = mem_rdata_i;
          state_d           = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = (state_q != ARB_IDLE);
  assign owner_o     = owner_q;
  assign mem_req_o   = (state_q == ARB_ISSUE);
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic             clk_i, rst_ni;
  logic [NR-1:0]    req_i, we_i;
  logic [NR*AW-1:0] addr_i;
  logic [NR*DW-1:0] wdata_i;
  logic [NR*BW-1:0] be_i;
  logic [NR-1:0]    gnt_o, rvalid_o;
  logic [DW-1:0]    rdata_o;
  logic             busy_o;
  logic [1:0]       owner_o;
  logic             mem_req_o, mem_we_o;
  logic [AW-1:0]    mem_addr_o;
  logic [DW-1:0]    mem_wdata_o;
  logic [BW-1:0]    mem_be_o;
  logic             mem_ready_i, mem_rvalid_i;
  logic [DW-1:0]    mem_rdata_i;

  int n_tests, n_fail;

  // Memory model knobs and state
  int unsigned stall_pct, stall_left, rsp_dly;
  int          rsp_cnt;
  logic [31:0] rsp_data, rsp_fixed;
  bit          rsp_fixed_en;

  mem_port_arbiter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .busy_o       (busy_o),
    .owner_o      (owner_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Advance one cycle: drive memory side at negedge, settle, then outputs may be sampled.
  task automatic step();
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom;
    if (rsp_cnt == 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rsp_data;
      rsp_cnt      = -1;
    end else if (rsp_cnt > 0) begin
      rsp_cnt--;
    end
    if (stall_left > 0) begin
      mem_ready_i = 1'b0;
      stall_left--;
    end else begin
      mem_ready_i = ($urandom_range(99) >= stall_pct);
    end
    #1;
    if (mem_req_o && mem_ready_i) begin
      rsp_cnt  = int'(rsp_dly) - 1;
      rsp_data = rsp_fixed_en ? rsp_fixed : $urandom;
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic [3:0] b);
    addr_i[i*AW +: AW]  = a;
    wdata_i[i*DW +: DW] = d;
    we_i[i]             = w;
    be_i[i*BW +: BW]    = b;
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    req_i      = '0;
    rsp_cnt    = -1;
    stall_left = 0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference arbitration rule: debug first; 1/2 alternate when round-robin is on.
  function automatic int model_pick(input logic [NR-1:0] p, input int last12);
    if (p[0]) return 0;
`ifdef ARB_ROUND_ROBIN_EN
    if (p[1] && p[2]) return (last12 == 1) ? 2 : 1;
`endif
    if (p[1]) return 1;
    return 2;
  endfunction

  task automatic test_reset();
    step();
    step();
    n_tests++;
    if ({gnt_o, rvalid_o, busy_o, owner_o, mem_req_o, mem_we_o, mem_be_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got gnt=%b rvalid=%b busy=%b owner=%0d mem_req=%b we=%b be=%h, required all 0",
               gnt_o, rvalid_o, busy_o, owner_o, mem_req_o, mem_we_o, mem_be_o);
    end
    n_tests++;
    if ({rdata_o, mem_addr_o, mem_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h, required 0", rdata_o, mem_addr_o,
               mem_wdata_o);
    end
    rst_ni = 1'b1;
    step();
    n_tests++;
    if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b mem_req=%b, required 0 0", busy_o, mem_req_o);
    end
  endtask

  task automatic test_single_read();
    int g_cnt = 0, r_cnt = 0, g_at = -1, r_at = -1;
    stall_pct = 0; rsp_dly = 2; rsp_fixed_en = 1; rsp_fixed = 32'hDEAD_BEEF;
    set_req(2, 32'h0000_0100, $urandom, 1'b0, 4'hF);
    req_i = 3'b100;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (gnt_o != '0) begin
        g_cnt++; g_at = c; req_i[2] = 1'b0;
        n_tests++;
        if (gnt_o !== 3'b100 || mem_addr_o !== 32'h100 || mem_we_o !== 1'b0 || owner_o !== 2'd2) begin
          n_fail++;
          $display("FAIL single_gnt: got gnt=%b addr=%h we=%b owner=%0d, required 100 00000100 0 2",
                   gnt_o, mem_addr_o, mem_we_o, owner_o);
        end
      end
      if (rvalid_o != '0) begin
        r_cnt++; r_at = c;
        n_tests++;
        if (rvalid_o !== 3'b100 || rdata_o !== 32'hDEAD_BEEF) begin
          n_fail++;
          $display("FAIL single_rvalid: got rvalid=%b rdata=%h, required 100 deadbeef", rvalid_o,
                   rdata_o);
        end
      end
    end
    rsp_fixed_en = 0;
    n_tests++;
    if (g_cnt != 1 || r_cnt != 1 || g_at != 1 || r_at != 4) begin
      n_fail++;
      $display("FAIL single_timing: got gnts=%0d@%0d rvalids=%0d@%0d, required 1@1 1@4", g_cnt, g_at,
               r_cnt, r_at);
    end
  endtask

  task automatic test_stall();
    bit done = 0;
    stall_pct = 0; rsp_dly = 1;
    set_req(1, 32'h20, 32'h1234_5678, 1'b1, 4'b0011);
    req_i = 3'b010;
    stall_left = 3;
    for (int c = 1; c <= 4; c++) begin
      step();
      n_tests++;
      if ({mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o} !==
          {1'b1, 32'h20, 32'h1234_5678, 1'b1, 4'b0011}) begin
        n_fail++;
        $display("FAIL stall_hold c%0d: got req=%b addr=%h wdata=%h we=%b be=%b, required 1 20 12345678 1 0011",
                 c, mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o);
      end
      n_tests++;
      if (gnt_o !== ((c == 4) ? 3'b010 : 3'b000)) begin
        n_fail++;
        $display("FAIL stall_gnt c%0d: got %b, required %b", c, gnt_o, (c == 4) ? 3'b010 : 3'b000);
      end
      if (gnt_o != '0) req_i[1] = 1'b0;
    end
    req_i = '0;
    for (int c = 0; c < 10 && !done; c++) begin
      step();
      if (rvalid_o != '0) done = 1;
    end
    n_tests++;
    if (!done || rvalid_o !== 3'b010) begin
      n_fail++;
      $display("FAIL stall_ack: got rvalid=%b done=%0d, required 010 1", rvalid_o, done);
    end
  endtask

  task automatic test_contention();
    int exp_ord[3] = '{0, 1, 2};
    int k = 0, nrv = 0, busy_gap = 0, last = -1;
    bit inflight = 0;
    do_reset();
    stall_pct = 30; rsp_dly = 2;
    for (int i = 0; i < NR; i++) set_req(i, $urandom, $urandom, 1'($urandom), 4'($urandom));
    req_i = 3'b111;
    for (int c = 0; c < 80 && nrv < 3; c++) begin
      step();
      if (rvalid_o != '0) begin
        inflight = 0; nrv++;
        n_tests++;
        if (oh_idx(rvalid_o) != last) begin
          n_fail++;
          $display("FAIL cont_route: got rvalid=%b, required index %0d", rvalid_o, last);
        end
      end
      if (gnt_o != '0) begin
        last = oh_idx(gnt_o);
        inflight = 1;
        req_i[last] = 1'b0;
        n_tests++;
        if (k > 2 || last != exp_ord[k] || owner_o !== 2'(last)) begin
          n_fail++;
          $display("FAIL cont_order #%0d: got gnt=%b owner=%0d, required index %0d", k, gnt_o,
                   owner_o, (k > 2) ? -1 : exp_ord[k]);
        end
        k++;
      end
      if (inflight && !busy_o) busy_gap++;
    end
    n_tests++;
    if (nrv != 3 || k != 3 || busy_gap != 0) begin
      n_fail++;
      $display("FAIL cont_summary: got grants=%0d rvalids=%0d busy_gaps=%0d, required 3 3 0", k, nrv,
               busy_gap);
    end
    req_i = '0;
  endtask

  task automatic test_round_robin();
    int exp_rr[4];
    int k = 0, nrv = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_rr = '{1, 2, 1, 2};
`else
    exp_rr = '{1, 1, 1, 1};
`endif
    do_reset();
    stall_pct = 20; rsp_dly = 1;
    set_req(1, 32'h1000, $urandom, 1'b0, 4'hF);
    set_req(2, 32'h2000, $urandom, 1'b0, 4'hF);
    req_i = 3'b110;
    for (int c = 0; c < 100 && nrv < 4; c++) begin
      step();
      if (rvalid_o != '0) nrv++;
      if (gnt_o != '0) begin
        n_tests++;
        if (k > 3 || oh_idx(gnt_o) != exp_rr[k]) begin
          n_fail++;
          $display("FAIL rr_order #%0d: got gnt=%b, required index %0d", k, gnt_o,
                   (k > 3) ? -1 : exp_rr[k]);
        end
        k++;
        if (k == 4) req_i = '0;
      end
    end
    n_tests++;
    if (k != 4 || nrv != 4) begin
      n_fail++;
      $display("FAIL rr_count: got grants=%0d rvalids=%0d, required 4 4", k, nrv);
    end
    req_i = '0;
  endtask

  task automatic test_stray_rvalid();
    logic [31:0] rd_before;
    stall_pct = 0; rsp_dly = 1;
    step();
    rd_before = rdata_o;
    rsp_cnt  = 0;
    rsp_data = $urandom;
    for (int c = 0; c < 4; c++) begin
      step();
      n_tests++;
      if (rvalid_o !== '0 || busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stray_idle c%0d: got rvalid=%b busy=%b mem_req=%b, required 000 0 0", c,
                 rvalid_o, busy_o, mem_req_o);
      end
    end
    n_tests++;
    if (rdata_o !== rd_before) begin
      n_fail++;
      $display("FAIL stray_rdata_hold: got %h, required %h", rdata_o, rd_before);
    end
    set_req(0, 32'h40, $urandom, 1'b0, 4'hF);
    req_i = 3'b001;
    step();
    n_tests++;
    if (gnt_o !== 3'b001) begin
      n_fail++;
      $display("FAIL stray_then_serve: got gnt=%b, required 001", gnt_o);
    end
    req_i = '0;
    for (int c = 0; c < 6; c++) step();
  endtask

  task automatic test_reset_mid_op();
    bit got = 0, done = 0;
    stall_pct = 0; rsp_dly = 4;
    set_req(1, 32'h80, $urandom, 1'b0, 4'hF);
    req_i = 3'b010;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      if (gnt_o != '0) got = 1;
    end
    req_i = '0;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL midrst_gnt: got no gnt, required gnt=010");
    end
    step();
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({gnt_o, rvalid_o, busy_o, owner_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL midrst_zero: got gnt=%b rvalid=%b busy=%b owner=%0d mem_req=%b addr=%h, required 0",
               gnt_o, rvalid_o, busy_o, owner_o, mem_req_o, mem_addr_o);
    end
    step();
    step();
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (rvalid_o !== '0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_no_rvalid c%0d: got rvalid=%b busy=%b, required 000 0", c, rvalid_o,
                 busy_o);
      end
    end
    rsp_dly = 2;
    set_req(2, 32'hC0, $urandom, 1'b0, 4'hF);
    req_i = 3'b100;
    got = 0;
    for (int c = 0; c < 12 && !done; c++) begin
      step();
      if (gnt_o != '0) begin got = 1; req_i = '0; end
      if (rvalid_o != '0) done = 1;
    end
    n_tests++;
    if (!got || !done || rvalid_o !== 3'b100 || rdata_o !== rsp_data) begin
      n_fail++;
      $display("FAIL midrst_recover: got gnt_seen=%0d rvalid=%b rdata=%h, required 1 100 %h", got,
               rvalid_o, rdata_o, rsp_data);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] p = '0;
    logic [31:0]   fa[NR], fd[NR];
    logic          fw[NR];
    logic [3:0]    fb[NR];
    int            last12 = 0, exp, bad;
    bit            got, done;
    do_reset();
    stall_pct = 30;
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (!p[i] && ($urandom_range(1) == 1)) begin
          fa[i] = $urandom; fd[i] = $urandom; fw[i] = 1'($urandom); fb[i] = 4'($urandom);
          set_req(i, fa[i], fd[i], fw[i], fb[i]);
          p[i] = 1'b1;
        end
      end
      if (p == '0) begin
        fa[1] = $urandom; fd[1] = $urandom; fw[1] = 1'($urandom); fb[1] = 4'($urandom);
        set_req(1, fa[1], fd[1], fw[1], fb[1]);
        p[1] = 1'b1;
      end
      req_i   = p;
      exp     = model_pick(p, last12);
      rsp_dly = $urandom_range(4, 1);
      got = 0; done = 0; bad = 0;
      for (int c = 0; c < 60 && !got; c++) begin
        step();
        if (gnt_o != '0) begin
          got = 1;
          n_tests++;
          if (gnt_o !== (NR'(1) << exp) || mem_addr_o !== fa[exp] || mem_wdata_o !== fd[exp] ||
              mem_we_o !== fw[exp] || mem_be_o !== fb[exp]) begin
            n_fail++;
            $display("FAIL rand_gnt t%0d: got gnt=%b addr=%h wdata=%h we=%b be=%h, required gnt idx %0d addr=%h wdata=%h we=%b be=%h",
                     t, gnt_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o, exp, fa[exp], fd[exp],
                     fw[exp], fb[exp]);
          end
          p[exp] = 1'b0;
          req_i  = p;
          if (exp != 0) last12 = exp;
        end
      end
      for (int c = 0; c < 20 && got && !done; c++) begin
        step();
        if (rvalid_o != '0) begin
          done = 1;
          n_tests++;
          if (rvalid_o !== (NR'(1) << exp) || rdata_o !== rsp_data) begin
            n_fail++;
            $display("FAIL rand_rvalid t%0d: got rvalid=%b rdata=%h, required idx %0d rdata=%h", t,
                     rvalid_o, rdata_o, exp, rsp_data);
          end
        end else if (gnt_o != '0 || !busy_o) begin
          bad++;
        end
      end
      n_tests++;
      if (!got || !done || bad != 0) begin
        n_fail++;
        $display("FAIL rand_progress t%0d: got gnt_seen=%0d rvalid_seen=%0d anomalies=%0d, required 1 1 0",
                 t, got, done, bad);
        do_reset();
        p = '0;
        last12 = 0;
      end
    end
    req_i = '0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_ni = 1'b0;
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    stall_pct = 0; stall_left = 0; rsp_dly = 1; rsp_cnt = -1;
    rsp_data = '0; rsp_fixed = '0; rsp_fixed_en = 0;
    test_reset();
    test_single_read();
    test_stall();
    test_contention();
    test_round_robin();
    test_stray_rvalid();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
